// File: rtl/debounce_pulse_sched_pkg.sv
// Shared definitions for the debounce pulse scheduler: FSM encoding and
// default sizing of the request bank and sample tick.
package debounce_pulse_sched_pkg;

  // Grant FSM states: waiting for a request, or offering a command.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  localparam int TICK_DIV_DEF = 50000;
  localparam int TICK_W_DEF   = 16;
  localparam int N_REQ_DEF    = 4;
  localparam int ID_W_DEF     = 2;

endpackage : debounce_pulse_sched_pkg

// File: rtl/debounce_pulse_sched_tick_gen.sv
// Free-running divider producing the 1-cycle sample tick that paces the
// debouncer shift registers. Runs regardless of the grant FSM.
module debounce_pulse_sched_tick_gen
  import debounce_pulse_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TICK_W   = TICK_W_DEF
) (
  input  logic clk_in,
  input  logic reset,
  output logic sample_tick
);

  localparam logic [TICK_W-1:0] LAST_CNT = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count_q;
  logic [TICK_W-1:0] count_d;
  logic              tick_q;
  logic              tick_d;

  // Next count wraps after TICK_DIV-1; the tick flop is loaded from the next
  // count so it is high exactly while the count sits at TICK_DIV-1.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (count_q == LAST_CNT) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
    if (count_d == LAST_CNT) begin
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

endmodule : debounce_pulse_sched_tick_gen

// File: rtl/debounce_pulse_sched.sv
// Debounce pulse scheduler: paces the debouncer bank, latches one-shot press
// pulses as pending requests and grants them round-robin to one consumer
// over a valid/ready handshake.
module debounce_pulse_sched
  import debounce_pulse_sched_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TICK_W   = TICK_W_DEF,
  parameter int ID_W     = ID_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [N_REQ-1:0] pulse_in,
  output logic             sample_tick,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  input  logic             cmd_ready,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow,
  input  logic             clr_overflow
);

  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  // First set request searching last+1, last+2, ... modulo N_REQ, so the
  // most recently granted index gets the lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  state_e            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  overflow_q, overflow_d;
  logic [N_REQ-1:0]  clr_mask_s;
  logic [N_REQ-1:0]  ovf_set_s;
  logic [ID_W-1:0]   pick_s;

  debounce_pulse_sched_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_gen (
    .clk_in      (clk_in),
    .reset       (reset),
    .sample_tick (sample_tick)
  );

  assign pick_s = rr_pick(pending_q, last_grant_q);

  // Grant FSM plus pending/overflow bookkeeping. A pulse landing on the bit
  // being issued re-arms it (set beats clear) and is not an overflow.
  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    last_grant_d = last_grant_q;
    clr_mask_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          cmd_id_d    = pick_s;
          clr_mask_s  = ONE_HOT0 << pick_s;
          cmd_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (cmd_valid_q && cmd_ready) begin
          last_grant_d = cmd_id_q;
          cmd_valid_d  = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_OFFER;
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    ovf_set_s = pulse_in & pending_q & ~clr_mask_s;
    pending_d = (pending_q & ~clr_mask_s) | pulse_in;
    if (clr_overflow) begin
      overflow_d = ovf_set_s;
    end else begin
      overflow_d = overflow_q | ovf_set_s;
    end
  end

  // State, command and request registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      last_grant_q <= LAST_IDX;
      pending_q    <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule : debounce_pulse_sched

// File: tb/tb_debounce_pulse_sched.sv
// Directed self-checking bench for debounce_pulse_sched (N_REQ=4, TICK_DIV=4).
module tb_debounce_pulse_sched;

  logic       clk_in;
  logic       reset;
  logic [3:0] pulse_in;
  logic       sample_tick;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       clr_overflow;

  int checks_cnt;
  int fail_cnt;

  debounce_pulse_sched #(
    .N_REQ    (4),
    .TICK_DIV (4),
    .TICK_W   (3),
    .ID_W     (2)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .sample_tick  (sample_tick),
    .cmd_valid    (cmd_valid),
    .cmd_id       (cmd_id),
    .cmd_ready    (cmd_ready),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pulse_in = 4'b0000;
    clr_overflow = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt = 0;
    reset = 1'b1;
    pulse_in = 4'b0000;
    cmd_ready = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1: reset values and tick cadence (cycle 1 = first cycle after release)
    check_eq("rst_tick", {31'd0, sample_tick}, 32'd0);
    check_eq("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("rst_id", {30'd0, cmd_id}, 32'd0);
    check_eq("rst_pending", {28'd0, pending}, 32'd0);
    check_eq("rst_overflow", {28'd0, overflow}, 32'd0);
    for (int c = 2; c <= 13; c++) begin
      step();
      check_eq($sformatf("tick_c%0d", c), {31'd0, sample_tick}, ((c % 4) == 0) ? 32'd1 : 32'd0);
    end

    // 2: single request, latency 2
    do_reset();
    cmd_ready = 1'b1;
    pulse_in = 4'b0001;
    step();
    pulse_in = 4'b0000;
    check_eq("t2_pend1", {28'd0, pending}, 32'h1);
    check_eq("t2_valid_c1", {31'd0, cmd_valid}, 32'd0);
    step();
    check_eq("t2_valid_c2", {31'd0, cmd_valid}, 32'd1);
    check_eq("t2_id", {30'd0, cmd_id}, 32'd0);
    check_eq("t2_pend_issued", {28'd0, pending}, 32'h0);
    step();
    check_eq("t2_valid_drop", {31'd0, cmd_valid}, 32'd0);

    // 3: all four at once, issued 0..3 with a gap cycle between
    do_reset();
    cmd_ready = 1'b1;
    pulse_in = 4'b1111;
    step();
    pulse_in = 4'b0000;
    check_eq("t3_pend", {28'd0, pending}, 32'hF);
    check_eq("t3_valid0", {31'd0, cmd_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq($sformatf("t3_valid_hi%0d", k), {31'd0, cmd_valid}, 32'd1);
      check_eq($sformatf("t3_id%0d", k), {30'd0, cmd_id}, k);
      step();
      check_eq($sformatf("t3_valid_lo%0d", k), {31'd0, cmd_valid}, 32'd0);
    end
    check_eq("t3_pend_end", {28'd0, pending}, 32'h0);

    // 4: backpressure holds offer of id 2; pulse[1] meanwhile is served next
    do_reset();
    cmd_ready = 1'b0;
    pulse_in = 4'b0100;
    step();
    pulse_in = 4'b0000;
    step();
    for (int h = 0; h < 5; h++) begin
      check_eq($sformatf("t4_hold_valid%0d", h), {31'd0, cmd_valid}, 32'd1);
      check_eq($sformatf("t4_hold_id%0d", h), {30'd0, cmd_id}, 32'd2);
      pulse_in = (h == 1) ? 4'b0010 : 4'b0000;
      step();
    end
    pulse_in = 4'b0000;
    check_eq("t4_hold_end", {30'd0, cmd_id}, 32'd2);
    check_eq("t4_pend_hold", {28'd0, pending}, 32'h2);
    cmd_ready = 1'b1;
    step();
    check_eq("t4_gap", {31'd0, cmd_valid}, 32'd0);
    step();
    check_eq("t4_next_valid", {31'd0, cmd_valid}, 32'd1);
    check_eq("t4_next_id", {30'd0, cmd_id}, 32'd1);
    pulse_in = 4'b1000;
    step();
    pulse_in = 4'b0000;
    check_eq("t4_gap2", {31'd0, cmd_valid}, 32'd0);
    step();
    check_eq("t4_last_id", {30'd0, cmd_id}, 32'd3);
    check_eq("t4_last_valid", {31'd0, cmd_valid}, 32'd1);

    // 5: overflow, clear, set-beats-clear and pulse on the bit being issued
    do_reset();
    cmd_ready = 1'b0;
    pulse_in = 4'b0001;
    step();
    pulse_in = 4'b0000;
    step();
    check_eq("t5_offer0", {30'd0, cmd_id}, 32'd0);
    pulse_in = 4'b1000;
    step();
    check_eq("t5_no_ovf_yet", {28'd0, overflow}, 32'h0);
    step();
    pulse_in = 4'b0000;
    check_eq("t5_ovf", {28'd0, overflow}, 32'h8);
    check_eq("t5_pend", {28'd0, pending}, 32'h8);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check_eq("t5_ovf_clr", {28'd0, overflow}, 32'h0);
    clr_overflow = 1'b1;
    pulse_in = 4'b1000;
    step();
    pulse_in = 4'b0000;
    check_eq("t5_set_beats_clr", {28'd0, overflow}, 32'h8);
    step();
    clr_overflow = 1'b0;
    check_eq("t5_ovf_clr2", {28'd0, overflow}, 32'h0);
    cmd_ready = 1'b1;
    step();
    check_eq("t5_idle_pend", {28'd0, pending}, 32'h8);
    pulse_in = 4'b1000;
    step();
    pulse_in = 4'b0000;
    check_eq("t5_issue_id", {30'd0, cmd_id}, 32'd3);
    check_eq("t5_issue_valid", {31'd0, cmd_valid}, 32'd1);
    check_eq("t5_rearm_pend", {28'd0, pending}, 32'h8);
    check_eq("t5_rearm_ovf", {28'd0, overflow}, 32'h0);

    // 6: reset during OFFER drops everything
    do_reset();
    cmd_ready = 1'b0;
    pulse_in = 4'b0001;
    step();
    pulse_in = 4'b0000;
    step();
    pulse_in = 4'b0110;
    step();
    pulse_in = 4'b0000;
    check_eq("t6_pre_pend", {28'd0, pending}, 32'h6);
    check_eq("t6_pre_valid", {31'd0, cmd_valid}, 32'd1);
    reset = 1'b1;
    #2;
    check_eq("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("t6_rst_id", {30'd0, cmd_id}, 32'd0);
    check_eq("t6_rst_pend", {28'd0, pending}, 32'h0);
    check_eq("t6_rst_ovf", {28'd0, overflow}, 32'h0);
    check_eq("t6_rst_tick", {31'd0, sample_tick}, 32'd0);
    step();
    reset = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("t6_quiet%0d", i), {31'd0, cmd_valid}, 32'd0);
    end
    check_eq("t6_pend_end", {28'd0, pending}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_debounce_pulse_sched
